fila_arbiter: RTL and testbench
===============================

# fila_arbiter

Write-port arbiter and occupancy tracker for the 8-entry byte queue (`fila`), clocked in the 10 kHz queue domain. It lets two byte producers (e.g. two deserializers) share the single `enqueue_in`/`data_in` port through a four-phase req/ack handshake with round-robin fairness. It keeps its own occupancy count so it never enqueues into a full queue. Its `enqueue_out` and `data_out` drive the queue directly. The consumer's `dequeue_in` is tapped so the count tracks reads.

## Interface
- `DEPTH`, default 8: queue capacity in entries.
- `LW`, default 4: occupancy width, equal to $clog2(DEPTH+1).
- `clk_10KHz`, input, 1: the only clock. All state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset (0 means reset).
- `req0_in`, input, 1: request from producer 0.
- `data0_in`, input, 8: byte from producer 0. Held stable while `req0_in` is 1.
- `ack0_out`, output, 1: one-cycle accept pulse to producer 0.
- `req1_in`, input, 1: request from producer 1.
- `data1_in`, input, 8: byte from producer 1. Held stable while `req1_in` is 1.
- `ack1_out`, output, 1: one-cycle accept pulse to producer 1.
- `dequeue_in`, input, 1: consumer read strobe, the same signal that drives the queue.
- `enqueue_out`, output, 1: one-cycle write strobe to the queue.
- `data_out`, output, 8: byte to the queue. Valid while `enqueue_out` is 1.
- `len_out`, output, LW: current occupancy, from 0 to DEPTH.
- `full_out`, output, 1: 1 when `len_out` equals DEPTH.
- `empty_out`, output, 1: 1 when `len_out` is 0.

## Operation
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - A grant happens when at least one request is present and `len_out` is below DEPTH.
  - Winner selection:
    - Only one request present: that requester wins.
    - Both present: the requester other than `last_grant` wins.
  - On a grant: latch the winner's data into `data_out`, record the winner, set `last_grant` to the winner, go to GRANT.
  - When `full_out` is 1, requests wait in IDLE without an ack.
- GRANT (lasts exactly one cycle):
  - `enqueue_out` is 1.
  - The winner's ack is 1. The other ack stays 0.
  - Next state is RELEASE.
- RELEASE:
  - Wait for the winner's req to return to 0 (four-phase handshake), then go to IDLE.
  - The other requester is not serviced until then.
- All outputs are registered. `ack0_out`, `ack1_out` and `enqueue_out` are never 1 outside GRANT.
- Occupancy counter:
  - Increment: `enqueue_out` is 1.
  - Decrement: `dequeue_in` is 1 and `len_out` is above 0.
  - Both in the same cycle: no change.
  - `dequeue_in` while empty: ignored, no underflow.
  - The counter never exceeds DEPTH, because a grant requires `len_out` below DEPTH at sampling and only one write is outstanding at a time.
- `full_out` and `empty_out` are derived from the registered `len_out` and update in the same cycle as `len_out`.
- `data_out` holds its last value outside GRANT. The queue ignores it while `enqueue_out` is 0.

## Timing
- Reset (`reset` is 0, asynchronous):
  - State IDLE.
  - `enqueue_out`, `ack0_out`, `ack1_out` are 0.
  - `data_out` is 8'h00.
  - `len_out` is 0.
  - `full_out` is 0 and `empty_out` is 1.
  - `last_grant` is 1, so producer 0 wins the first tie.
- Reset during GRANT or RELEASE aborts the transfer and clears the count.
  - A producer still holding req after reset is granted again. Its byte is re-sent, and the count restarts from 0.
- Grant latency:
  - A request sampled in IDLE at edge k makes `enqueue_out` and ack 1 during the cycle after edge k.
  - `len_out` shows +1 after edge k+1.
- Minimum spacing between two accepted bytes is 3 cycles: GRANT, RELEASE (req dropped), IDLE sample.
  - A winner that drops req during its ack cycle lets RELEASE exit at the next edge.
- A dequeue that lowers `len_out` from DEPTH lets a waiting request be sampled at the following edge.
- A request raised in the same cycle as the other producer's grant is held until RELEASE exits.

## Test plan
- Single producer: after reset, `req0_in` is 1 with 8'hA5. Required: `enqueue_out` is 1 for 1 cycle with `data_out` 8'hA5, `ack0_out` pulses in that same cycle, and `len_out` becomes 1. Drop req; the FSM returns to IDLE with no second enqueue.
- Fairness: both requests held continuously, `data0_in` 8'h11 and `data1_in` 8'h22, with four-phase toggling. Required grant order: 0, 1, 0, 1. The queue receives 11, 22, 11, 22.
- Full: fill 8 bytes with no dequeue. Required: `len_out` is 8, `full_out` is 1, and a 9th request gets no ack. One `dequeue_in` pulse brings `len_out` to 7, and then the waiting request is acked. `len_out` returns to 8.
- Simultaneous events: `enqueue_out` and `dequeue_in` in the same cycle at `len_out` 3 leaves `len_out` at 3. `dequeue_in` at `len_out` 0 leaves `len_out` at 0 and `empty_out` at 1.
- Mid-transfer reset: assert `reset` low during GRANT. Required: all outputs return to reset values immediately (asynchronously). With req still 1 after reset release, the byte is re-granted and `len_out` becomes 1.
- Hold-off: producer 1 holds req during RELEASE of producer 0 while producer 0 keeps req at 1 for 5 cycles. Required: `ack1_out` stays 0 until 2 cycles after `req0_in` falls.

Source files
------------

// File: rtl/fila_arbiter.sv
// fila_arbiter: round-robin four-phase write-port arbiter and occupancy tracker
// for the 8-entry byte queue, clocked in the 10 kHz queue domain.
module fila_arbiter #(
   parameter int DEPTH = 8,
   parameter int LW    = 4
) (
   input  logic          clk_10KHz,
   input  logic          reset,
   input  logic          req0_in,
   input  logic [7:0]    data0_in,
   output logic          ack0_out,
   input  logic          req1_in,
   input  logic [7:0]    data1_in,
   output logic          ack1_out,
   input  logic          dequeue_in,
   output logic          enqueue_out,
   output logic [7:0]    data_out,
   output logic [LW-1:0] len_out,
   output logic          full_out,
   output logic          empty_out
);
   localparam logic [1:0]    IDLE    = 2'd0;
   localparam logic [1:0]    GRANT   = 2'd1;
   localparam logic [1:0]    RELEASE = 2'd2;
   localparam logic [LW-1:0] FULL    = LW'(DEPTH);
   logic [1:0] state;
   logic       winner;
   logic       last_grant;
   logic       pick1;
   logic       go;
   logic       dec;
   // on a tie the producer that did not win last time is served
   assign pick1     = req1_in && (!req0_in || !last_grant);
   assign go        = (req0_in || req1_in) && (len_out < FULL);
   assign dec       = dequeue_in && (len_out != '0);
   assign full_out  = len_out == FULL;
   assign empty_out = len_out == '0;
   always_ff @(posedge clk_10KHz or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         winner      <= 1'b0;
         last_grant  <= 1'b1;
         data_out    <= 8'h00;
         enqueue_out <= 1'b0;
         ack0_out    <= 1'b0;
         ack1_out    <= 1'b0;
      end else begin
         enqueue_out <= 1'b0;
         ack0_out    <= 1'b0;
         ack1_out    <= 1'b0;
         case (state)
            IDLE:
               if (go) begin
                  state       <= GRANT;
                  winner      <= pick1;
                  last_grant  <= pick1;
                  data_out    <= pick1 ? data1_in : data0_in;
                  enqueue_out <= 1'b1;
                  ack0_out    <= !pick1;
                  ack1_out    <= pick1;
               end
            GRANT:   state <= RELEASE;
            RELEASE: if (!(winner ? req1_in : req0_in)) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   always_ff @(posedge clk_10KHz or negedge reset) begin
      if (!reset) len_out <= '0;
      else if (enqueue_out && !dec) len_out <= len_out + LW'(1);
      else if (dec && !enqueue_out) len_out <= len_out - LW'(1);
   end
endmodule

// File: tb/tb_fila_arbiter.sv
// tb_fila_arbiter: directed checks of handshake timing, fairness, full
// hold-off, counter corner cases and asynchronous mid-transfer reset.
module tb_fila_arbiter;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0, dequeue = 1'b0;
   logic [7:0] data0 = 8'h00, data1 = 8'h00;
   logic       ack0, ack1, enqueue, full, empty;
   logic [7:0] data_out;
   logic [3:0] len;
   int         checks = 0;
   int         failures = 0;

   fila_arbiter dut (
      .clk_10KHz(clk), .reset(reset),
      .req0_in(req0), .data0_in(data0), .ack0_out(ack0),
      .req1_in(req1), .data1_in(data1), .ack1_out(ack1),
      .dequeue_in(dequeue), .enqueue_out(enqueue), .data_out(data_out),
      .len_out(len), .full_out(full), .empty_out(empty)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_enq"}, enqueue, 0);
      chk({tag, "_ack0"}, ack0, 0);
      chk({tag, "_ack1"}, ack1, 0);
      chk({tag, "_data"}, data_out, 8'h00);
      chk({tag, "_len"}, len, 0);
      chk({tag, "_full"}, full, 0);
      chk({tag, "_empty"}, empty, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      tick(2);
      chk_reset("reset");
      reset = 1'b1;
      tick(1);
      // single producer
      req0 = 1'b1; data0 = 8'hA5;
      tick(1);
      chk("single_enq", enqueue, 1);
      chk("single_ack0", ack0, 1);
      chk("single_ack1", ack1, 0);
      chk("single_data", data_out, 8'hA5);
      chk("single_len_pre", len, 0);
      req0 = 1'b0;
      tick(1);
      chk("single_enq_off", enqueue, 0);
      chk("single_len", len, 1);
      chk("single_empty", empty, 0);
      tick(3);
      chk("single_no_second", enqueue, 0);
      chk("single_len_hold", len, 1);
      // dequeue down to empty, then underflow attempt
      dequeue = 1'b1;
      tick(1);
      chk("deq_len", len, 0);
      tick(1);
      chk("underflow_len", len, 0);
      chk("underflow_empty", empty, 1);
      dequeue = 1'b0;
      // asynchronous reset pulse restores the tie-break to producer 0
      reset = 1'b0;
      #1;
      chk("areset_len", len, 0);
      reset = 1'b1;
      tick(1);
      // fairness, four-phase
      req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         chk("fair_enq", enqueue, 1);
         chk("fair_data", data_out, (i % 2) ? 8'h22 : 8'h11);
         chk("fair_ack0", ack0, (i % 2) ? 0 : 1);
         chk("fair_ack1", ack1, (i % 2) ? 1 : 0);
         if (i % 2) req1 = 1'b0; else req0 = 1'b0;
         tick(2);
         req0 = 1'b1; req1 = 1'b1;
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("fair_len", len, 4);
      // simultaneous enqueue and dequeue at len 3
      dequeue = 1'b1;
      tick(1);
      dequeue = 1'b0;
      chk("sim_len3", len, 3);
      req0 = 1'b1; data0 = 8'h33;
      tick(1);
      chk("sim_enq", enqueue, 1);
      dequeue = 1'b1; req0 = 1'b0;
      tick(1);
      dequeue = 1'b0;
      chk("sim_len_same", len, 3);
      tick(1);
      // fill to full
      for (int i = 0; i < 5; i++) begin
         req0 = 1'b1; data0 = 8'(8'h40 + i);
         tick(1);
         chk("fill_enq", enqueue, 1);
         req0 = 1'b0;
         tick(2);
      end
      chk("full_len", len, 8);
      chk("full_flag", full, 1);
      chk("full_empty", empty, 0);
      req1 = 1'b1; data1 = 8'h99;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("full_no_ack1", ack1, 0);
         chk("full_no_enq", enqueue, 0);
      end
      dequeue = 1'b1;
      tick(1);
      dequeue = 1'b0;
      chk("full_deq_len", len, 7);
      chk("full_deq_flag", full, 0);
      chk("full_deq_no_ack", ack1, 0);
      tick(1);
      chk("full_late_ack1", ack1, 1);
      chk("full_late_enq", enqueue, 1);
      chk("full_late_data", data_out, 8'h99);
      req1 = 1'b0;
      tick(1);
      chk("full_again_len", len, 8);
      chk("full_again_flag", full, 1);
      tick(1);
      // hold-off
      dequeue = 1'b1;
      tick(3);
      dequeue = 1'b0;
      chk("hold_len5", len, 5);
      req0 = 1'b1; data0 = 8'h44;
      tick(1);
      chk("hold_ack0", ack0, 1);
      chk("hold_data0", data_out, 8'h44);
      req1 = 1'b1; data1 = 8'h55;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         chk("hold_no_ack1", ack1, 0);
         chk("hold_no_enq", enqueue, 0);
      end
      req0 = 1'b0;
      tick(1);
      chk("hold_after1_ack1", ack1, 0);
      tick(1);
      chk("hold_after2_ack1", ack1, 1);
      chk("hold_data1", data_out, 8'h55);
      chk("hold_len6", len, 6);
      req1 = 1'b0;
      tick(1);
      chk("hold_len7", len, 7);
      tick(1);
      // mid-transfer reset
      req0 = 1'b1; data0 = 8'h77;
      tick(1);
      chk("mid_enq", enqueue, 1);
      reset = 1'b0;
      #1;
      chk_reset("mid_reset");
      reset = 1'b1;
      tick(1);
      chk("mid_regrant_enq", enqueue, 1);
      chk("mid_regrant_ack0", ack0, 1);
      chk("mid_regrant_data", data_out, 8'h77);
      req0 = 1'b0;
      tick(1);
      chk("mid_len", len, 1);
      tick(1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
